// File: rtl/mux_arb_pkg.sv
// ============================================================================
// Module   : mux_arb_pkg
// Brief    : Shared constants, select type and pointer helper for the
//            round-robin mux arbiter family.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mux_arb_pkg;

    localparam int N_DEFAULT     = 4;
    localparam int WIDTH_DEFAULT = 2;
    localparam int CNT_W         = 8;
    localparam int SEL_W         = $clog2(N_DEFAULT);

    typedef logic [SEL_W-1:0] sel_t;

    // Priority pointer moves to the lane just after the winner.
    function automatic sel_t next_ptr(input sel_t g);
        return sel_t'((int'(g) + 1) % N_DEFAULT);
    endfunction

endpackage

`default_nettype wire

// File: rtl/rr_pick.sv
// ============================================================================
// Module   : rr_pick
// Brief    : Combinational round-robin pick: rotate requests by ptr, take the
//            lowest set bit, rotate the index back. Library-reusable.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_pick #(
    parameter  int N     = 4,
    localparam int SEL_W = $clog2(N)
) (
    input  logic [N-1:0]     V,
    input  logic [SEL_W-1:0] ptr,
    output logic [SEL_W-1:0] g,
    output logic             hit
);

    logic [2*N-1:0]   w_dbl;
    logic [N-1:0]     w_rot;
    logic [SEL_W-1:0] w_idx;

    // Bit j of w_rot is lane (ptr + j) mod N.
    assign w_dbl = {V, V};
    assign w_rot = w_dbl[ptr +: N];

    always_comb begin
        w_idx = '0;
        for (int j = N - 1; j >= 0; j--) begin
            if (w_rot[j]) begin
                w_idx = SEL_W'(j);
            end
        end
    end

    // N is a power of two, so the SEL_W-bit sum wraps modulo N.
    assign g   = ptr + w_idx;
    assign hit = |V;

endmodule

`default_nettype wire

// File: rtl/mux_rr_arbiter.sv
// ============================================================================
// Module   : mux_rr_arbiter
// Brief    : Round-robin arbiter sharing one N:1 mux into a registered
//            valid/ready output stage. Optional grant counters are enabled
//            with the macro MUX_RR_ARBITER_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mux_rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter  int N     = N_DEFAULT,
    parameter  int WIDTH = WIDTH_DEFAULT,
    localparam int SEL_W = $clog2(N)
) (
    input  logic               CLK,
    input  logic               ASYNCRESET,
    input  logic [N*WIDTH-1:0] I,
    input  logic [N-1:0]       V,
    output logic [N-1:0]       R,
    output logic [WIDTH-1:0]   O,
    output logic [SEL_W-1:0]   S,
    output logic               O_valid,
`ifdef MUX_RR_ARBITER_STATS_EN
    input  logic               CNT_CLR,
    output logic [N*CNT_W-1:0] GRANT_CNT,
`endif
    input  logic               O_ready
);

    logic [SEL_W-1:0] r_ptr;
    logic [WIDTH-1:0] r_o;
    logic [SEL_W-1:0] r_s;
    logic             r_valid;

    logic [SEL_W-1:0] w_g;
    logic [SEL_W-1:0] w_ptr_nxt;
    logic             w_hit;
    logic             w_acc;
    logic             w_load;
    logic [WIDTH-1:0] w_lane;

    rr_pick #(
        .N   (N)
    ) u_pick (
        .V   (V),
        .ptr (r_ptr),
        .g   (w_g),
        .hit (w_hit)
    );

    generate
        if (SEL_W == mux_arb_pkg::SEL_W) begin : g_pkg_ptr
            assign w_ptr_nxt = next_ptr(w_g);
        end else begin : g_gen_ptr
            assign w_ptr_nxt = w_g + SEL_W'(1);
        end
    endgenerate

    assign w_acc  = !r_valid || O_ready;
    assign w_load = w_acc && w_hit;
    assign w_lane = I[w_g*WIDTH +: WIDTH];

    // Grant is gated by reset so no requester sees a handshake while held.
    always_comb begin
        R = '0;
        if (w_load && !ASYNCRESET) begin
            R[w_g] = 1'b1;
        end
    end

    always_ff @(posedge CLK or posedge ASYNCRESET) begin
        if (ASYNCRESET) begin
            r_o     <= '0;
            r_s     <= '0;
            r_valid <= 1'b0;
            r_ptr   <= '0;
        end else if (w_load) begin
            r_o     <= w_lane;
            r_s     <= w_g;
            r_valid <= 1'b1;
            r_ptr   <= w_ptr_nxt;
        end else if (w_acc) begin
            r_valid <= 1'b0;
        end
    end

    assign O       = r_o;
    assign S       = r_s;
    assign O_valid = r_valid;

`ifdef MUX_RR_ARBITER_STATS_EN
    logic [N-1:0][CNT_W-1:0] r_cnt;

    always_ff @(posedge CLK or posedge ASYNCRESET) begin
        if (ASYNCRESET) begin
            r_cnt <= '0;
        end else if (CNT_CLR) begin
            r_cnt <= '0;
        end else begin
            for (int k = 0; k < N; k++) begin
                if (V[k] && R[k] && (r_cnt[k] != '1)) begin
                    r_cnt[k] <= r_cnt[k] + CNT_W'(1);
                end
            end
        end
    end

    assign GRANT_CNT = r_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mux_rr_arbiter.sv
// ============================================================================
// Module   : tb_mux_rr_arbiter
// Brief    : Scoreboard bench for mux_rr_arbiter: directed scenarios plus
//            randomized traffic against a behavioural round-robin model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mux_rr_arbiter;

    localparam int N = 4;
    localparam int W = 2;

    logic           CLK = 1'b0;
    logic           ASYNCRESET;
    logic [N*W-1:0] I;
    logic [N-1:0]   V;
    logic [N-1:0]   R;
    logic [W-1:0]   O;
    logic [1:0]     S;
    logic           O_valid;
    logic           O_ready;
`ifdef MUX_RR_ARBITER_STATS_EN
    logic           CNT_CLR;
    logic [N*8-1:0] GRANT_CNT;
    int             m_cnt [N];
`endif

    mux_rr_arbiter #(.N(N), .WIDTH(W)) dut (
        .CLK        (CLK),
        .ASYNCRESET (ASYNCRESET),
        .I          (I),
        .V          (V),
        .R          (R),
        .O          (O),
        .S          (S),
        .O_valid    (O_valid),
`ifdef MUX_RR_ARBITER_STATS_EN
        .CNT_CLR    (CNT_CLR),
        .GRANT_CNT  (GRANT_CNT),
`endif
        .O_ready    (O_ready)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [1:0] sel;
        logic [1:0] data;
    } exp_t;

    exp_t sb_q[$];
    int   checks     = 0;
    int   passes     = 0;
    int   m_ptr      = 0;
    bit   m_valid    = 1'b0;
    int   pushed_now = 0;
    bit   in_reset   = 1'b1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Called at posedge+1; applies inputs, checks the grant, returns at next posedge+1.
    task automatic drive(input logic [N-1:0] v, input logic [N*W-1:0] d, input logic rdy,
                         output int gl);
        bit acc;
        logic [N-1:0] exp_r;
        exp_t e;
        V = v; I = d; O_ready = rdy;
        #1;
        acc = !m_valid || rdy;
        gl = -1;
        if (acc) begin
            for (int i = 0; i < N; i++) begin
                if (gl < 0 && v[(m_ptr + i) % N]) gl = (m_ptr + i) % N;
            end
        end
        exp_r = (gl >= 0) ? (N'(1) << gl) : '0;
        chk("grant", R, exp_r);
        if (gl >= 0) begin
            e.sel  = 2'(gl);
            e.data = d[gl*W +: W];
            sb_q.push_back(e);
            m_ptr      = (gl + 1) % N;
            m_valid    = 1'b1;
            pushed_now = 1;
        end else if (acc) begin
            m_valid = 1'b0;
        end
`ifdef MUX_RR_ARBITER_STATS_EN
        for (int k = 0; k < N; k++) begin
            if (CNT_CLR) m_cnt[k] = 0;
            else if (k == gl && m_cnt[k] < 255) m_cnt[k]++;
        end
`endif
        @(posedge CLK);
        #1;
        pushed_now = 0;
`ifdef MUX_RR_ARBITER_STATS_EN
        for (int k = 0; k < N; k++) chk("grant_cnt", GRANT_CNT[k*8 +: 8], m_cnt[k]);
`endif
    endtask

    // Monitor: mid-cycle, compares the presented word whenever it is consumed.
    initial begin
        exp_t e;
        forever begin
            @(negedge CLK);
            if (!in_reset) begin
                chk("o_valid", O_valid, sb_q.size() > pushed_now);
                if (O_valid && O_ready && sb_q.size() > 0) begin
                    e = sb_q.pop_front();
                    chk("o_data", O, e.data);
                    chk("o_sel", S, e.sel);
                end
            end
        end
    end

    task automatic model_reset();
        sb_q.delete();
        m_ptr   = 0;
        m_valid = 1'b0;
`ifdef MUX_RR_ARBITER_STATS_EN
        for (int k = 0; k < N; k++) m_cnt[k] = 0;
`endif
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int gl;
        logic [W-1:0]   o_prev;
        logic [1:0]     s_prev;
        logic [N-1:0]   v_cur;
        logic [N*W-1:0] d_cur;

        ASYNCRESET = 1'b1; V = 4'hF; I = '0; O_ready = 1'b0;
`ifdef MUX_RR_ARBITER_STATS_EN
        CNT_CLR = 1'b0;
`endif
        model_reset();
        repeat (2) @(posedge CLK);
        #2;
        chk("rst_o_valid", O_valid, 0);
        chk("rst_s", S, 0);
        chk("rst_o", O, 0);
        chk("rst_r", R, 0);
        V = '0;
        #1 ASYNCRESET = 1'b0;
        in_reset = 1'b0;
        @(posedge CLK);
        #1;

        // Round robin with lane k carrying value k.
        for (int i = 0; i < 8; i++) begin
            drive(4'b1111, 8'b11_10_01_00, 1'b1, gl);
            chk("rr_order", gl, i % N);
        end

        // Mid-stream asynchronous reset between edges.
        #2;
        in_reset = 1'b1;
        ASYNCRESET = 1'b1;
        #1;
        chk("mid_rst_o_valid", O_valid, 0);
        chk("mid_rst_s", S, 0);
        chk("mid_rst_r", R, 0);
        #2 V = '0;
        #1 ASYNCRESET = 1'b0;
        model_reset();
        in_reset = 1'b0;
        @(posedge CLK);
        #1;
        drive(4'b1111, 8'b00_01_10_11, 1'b1, gl);
        chk("post_rst_first", gl, 0);

        // Sparse with wrap: lane 2 grant puts ptr at 3, then 0,2,0.
        drive(4'b0100, 8'b00_10_00_00, 1'b1, gl);
        drive(4'b0101, 8'b00_01_00_10, 1'b1, gl);
        chk("wrap_0", gl, 0);
        drive(4'b0101, 8'b00_11_00_01, 1'b1, gl);
        chk("wrap_2", gl, 2);
        drive(4'b0101, 8'b00_10_00_11, 1'b1, gl);
        chk("wrap_0b", gl, 0);

        // Backpressure: output held, no grants.
        o_prev = O; s_prev = S;
        for (int i = 0; i < 5; i++) begin
            drive(4'b0010, 8'b00_00_10_00, 1'b0, gl);
            chk("bp_o_hold", O, o_prev);
            chk("bp_s_hold", S, s_prev);
        end
        drive(4'b0010, 8'b00_00_10_00, 1'b1, gl);
        chk("bp_release", gl, 1);
        chk("bp_new_s", S, 1);
        chk("bp_new_o", O, 2);

        // Idle drain after a lane-3 word; ptr must come back to 0.
        drive(4'b1000, 8'b01_00_00_00, 1'b1, gl);
        drive(4'b0000, 8'b00_00_00_00, 1'b1, gl);
        chk("drain_valid", O_valid, 0);
        drive(4'b0000, 8'b00_00_00_00, 1'b1, gl);
        drive(4'b1001, 8'b10_00_00_01, 1'b1, gl);
        chk("drain_ptr", gl, 0);

`ifdef MUX_RR_ARBITER_STATS_EN
        for (int i = 0; i < 300; i++) drive(4'b0010, 8'b00_00_01_00, 1'b1, gl);
        chk("stats_sat", GRANT_CNT[15:8], 255);
        CNT_CLR = 1'b1;
        drive(4'b0010, 8'b00_00_01_00, 1'b1, gl);
        CNT_CLR = 1'b0;
        chk("stats_clr", GRANT_CNT[15:8], 0);
`endif

        // Randomized traffic honouring the hold-until-granted contract.
        v_cur = '0; d_cur = '0;
        for (int i = 0; i < 400; i++) begin
            for (int k = 0; k < N; k++) begin
                if (!v_cur[k] && $urandom_range(0, 1) == 1) begin
                    v_cur[k] = 1'b1;
                    d_cur[k*W +: W] = W'($urandom);
                end
            end
            drive(v_cur, d_cur, $urandom_range(0, 3) != 0, gl);
            if (gl >= 0) v_cur[gl] = 1'b0;
        end

        for (int i = 0; i < 3; i++) drive('0, '0, 1'b1, gl);
        chk("sb_empty", sb_q.size(), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

`default_nettype wire
